// File: rtl/mbist_pkg.sv
// March C- table and shared types for the memory BIST controller.
// Elements E0..E5, each with up to two ops per address and a sweep direction.
package mbist_pkg;

  localparam int NUM_ELEM = 6;

  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;
  typedef enum logic [2:0] {RD0, RD1, WR0, WR1, NONE} op_e;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} wphase_e;

  typedef struct packed {
    op_e  op0;
    op_e  op1;
    logic down;
  } march_t;

  localparam march_t MARCH [NUM_ELEM] = '{
    '{op0: WR0, op1: NONE, down: 1'b0},
    '{op0: RD0, op1: WR1,  down: 1'b0},
    '{op0: RD1, op1: WR0,  down: 1'b0},
    '{op0: RD0, op1: WR1,  down: 1'b1},
    '{op0: RD1, op1: WR0,  down: 1'b1},
    '{op0: RD0, op1: NONE, down: 1'b0}
  };

  function automatic logic op_is_wr(input op_e op);
    return (op == WR0) || (op == WR1);
  endfunction

  // Data polarity of an op: 1 means all-ones.
  function automatic logic op_data(input op_e op);
    return (op == RD1) || (op == WR1);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for March sweeps; load picks the first address of a sweep.
// Single-cycle step; last flags the final address in the loaded direction.
module mbist_addr_gen #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              down,
  input  logic              step,
  output logic [AWIDTH-1:0] addr,
  output logic              last
);

  localparam logic [AWIDTH-1:0] TOP = AWIDTH'(DEPTH - 1);

  logic dir_down;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      dir_down <= 1'b0;
    end else if (load) begin
      dir_down <= down;
      addr     <= down ? TOP : '0;
    end else if (step) begin
      addr <= dir_down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = dir_down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/mbist_ctrl.sv
// March C- BIST controller: owns the RAM port while busy, else passes sys_* through.
// 25*DEPTH op cycles after start; start ignored while running, sys_wr dropped while busy.
module mbist_ctrl
  import mbist_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 2,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int ERRW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [WIDTH-1:0]  fail_data,
  output logic [ERRW-1:0]   err_count,
  input  logic              sys_wr,
  input  logic [AWIDTH-1:0] sys_addr,
  input  logic [WIDTH-1:0]  sys_din,
  output logic [WIDTH-1:0]  sys_dout,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_din,
  input  logic [WIDTH-1:0]  mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state;
  elem_e             elem;
  logic              op_idx;
  wphase_e           phase;
  logic              bist_wr;
  logic [WIDTH-1:0]  bist_din;
  logic [AWIDTH-1:0] bist_addr;
  logic              addr_last;

  march_t  cur_m, nxt_m;
  op_e     cur_op, nxt_op;
  elem_e   elem_nxt;
  logic    cur_wr, op_last_cyc, elem_last_op, elem_end, test_end;
  logic    running, start_accept, mismatch;
  logic    ag_load, ag_down, ag_step;

  always_comb begin
    running      = (state == S_RUN);
    start_accept = start && (state == S_IDLE || state == S_DONE);
    cur_m        = MARCH[elem];
    cur_op       = op_idx ? cur_m.op1 : cur_m.op0;
    cur_wr       = op_is_wr(cur_op);
    // Reads use the first two phase codes as their two cycles.
    op_last_cyc  = cur_wr ? (phase == PH_HOLD) : (phase == PH_PULSE);
    elem_last_op = op_idx || (cur_m.op1 == NONE);
    elem_end     = elem_last_op && addr_last;
    test_end     = elem_end && (elem == E5);
    elem_nxt     = (elem == E5) ? E5 : elem_e'(elem + 3'd1);
    nxt_m        = MARCH[elem_nxt];
    if (!elem_last_op)   nxt_op = cur_m.op1;
    else if (!addr_last) nxt_op = cur_m.op0;
    else                 nxt_op = nxt_m.op0;
    mismatch = running && !cur_wr && (phase == PH_PULSE) &&
               (mem_dout != {WIDTH{op_data(cur_op)}});
    ag_step  = running && op_last_cyc && elem_last_op && !addr_last;
    ag_load  = start_accept || (running && op_last_cyc && elem_end && !test_end);
    ag_down  = start_accept ? 1'b0 : nxt_m.down;
  end

  mbist_addr_gen #(.DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (ag_load),
    .down (ag_down),
    .step (ag_step),
    .addr (bist_addr),
    .last (addr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      elem      <= E0;
      op_idx    <= 1'b0;
      phase     <= PH_SETUP;
      bist_wr   <= 1'b0;
      bist_din  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            elem      <= E0;
            op_idx    <= 1'b0;
            phase     <= PH_SETUP;
            bist_wr   <= 1'b0;
            bist_din  <= {WIDTH{op_data(MARCH[0].op0)}};
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
            err_count <= '0;
          end
        end
        S_RUN: begin
          if (mismatch) begin
            if (err_count != {ERRW{1'b1}}) err_count <= err_count + 1'b1;
            if (!fail) begin
              fail      <= 1'b1;
              fail_addr <= bist_addr;
              fail_elem <= elem;
              fail_data <= mem_dout;
            end
          end
          if (!op_last_cyc) begin
            phase   <= wphase_e'(phase + 2'd1);
            bist_wr <= cur_wr && (phase == PH_SETUP);
          end else begin
            bist_wr <= 1'b0;
            phase   <= PH_SETUP;
            if (test_end) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              op_idx   <= !elem_last_op;
              bist_din <= {WIDTH{op_data(nxt_op)}};
              if (elem_end) elem <= elem_nxt;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wr   = busy ? bist_wr   : sys_wr;
    mem_addr = busy ? bist_addr : sys_addr;
    mem_din  = busy ? bist_din  : sys_din;
    sys_dout = mem_dout;
  end

endmodule
